// File: rtl/serdesphy_i2c_pkg.sv
// Shared definitions for the SerDes PHY I2C target blocks.
//   i2c_state_e      : protocol state of the target FSM
//   I2C_ACK/I2C_NACK : SDA level of an acknowledge / not-acknowledge bit
//   I2C_DEFAULT_ADDR : default 7-bit target address
package serdesphy_i2c_pkg;

  localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h42;
  localparam logic       I2C_ACK          = 1'b0;
  localparam logic       I2C_NACK         = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_DEV_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_HACK,
    ST_IGNORE
  } i2c_state_e;

endpackage

// File: rtl/serdesphy_i2c_regbank_if.sv
// I2C pad-side bus bundle for the register-bank target.
//   scl_in  : I2C clock from pad
//   sda_in  : resolved SDA from pad
//   sda_out : level driven when sda_oe=1 (always 0, open-drain)
//   sda_oe  : pull SDA low
interface serdesphy_i2c_regbank_if;

  logic scl_in;
  logic sda_in;
  logic sda_out;
  logic sda_oe;

  modport slave  (input scl_in, input sda_in, output sda_out, output sda_oe);
  modport master (output scl_in, output sda_in, input sda_out, input sda_oe);

endinterface

// File: rtl/serdesphy_i2c_sync.sv
// SCL/SDA synchroniser with edge, START and STOP detection.
//   clk, rst    : system clock, async active-high reset
//   scl_i/sda_i : raw pad inputs
//   sda_o       : synchronised SDA
//   scl_rise_o  : one-cycle pulse on synchronised SCL rising edge
//   scl_fall_o  : one-cycle pulse on synchronised SCL falling edge
//   start_o     : SDA fell while SCL high
//   stop_o      : SDA rose while SCL high
module serdesphy_i2c_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_hist_q;
  logic                   sda_hist_q;
  logic                   scl_s;

  // Reset to the idle bus level so leaving reset never looks like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_hist_q <= scl_sync_q[SYNC_STAGES-1];
      sda_hist_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_o      = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise_o = scl_s & ~scl_hist_q;
  assign scl_fall_o = ~scl_s & scl_hist_q;
  // SCL must be high on both sides of the SDA edge.
  assign start_o    = scl_s & scl_hist_q & sda_hist_q & ~sda_o;
  assign stop_o     = scl_s & scl_hist_q & ~sda_hist_q & sda_o;

endmodule

// File: rtl/serdesphy_i2c_regbank.sv
// I2C target with configuration register bank.
//   clk, rst  : system clock, async active-high reset
//   i2c       : pad-side SCL/SDA bundle (slave modport)
//   reg_q     : flat register contents, read-only entries read 0
//   ro_data   : live values returned for read-only registers
//   wr_strobe : one-cycle pulse per committed write
//   wr_addr   : register index of last write
//   wr_data   : byte of last write
//   busy      : high from START to STOP/reset
module serdesphy_i2c_regbank
  import serdesphy_i2c_pkg::*;
#(
  parameter logic [6:0]            I2C_ADDR    = I2C_DEFAULT_ADDR,
  parameter int unsigned           NUM_REGS    = 8,
  parameter logic [NUM_REGS-1:0]   RO_MASK     = NUM_REGS'(64),
  parameter logic [NUM_REGS*8-1:0] RESET_VAL   = '0,
  parameter int unsigned           SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  serdesphy_i2c_regbank_if.slave  i2c,
  output logic [NUM_REGS*8-1:0]   reg_q,
  input  logic [NUM_REGS*8-1:0]   ro_data,
  output logic                    wr_strobe,
  output logic [7:0]              wr_addr,
  output logic [7:0]              wr_data,
  output logic                    busy
);

  localparam int unsigned PTR_W = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1;

  logic                         sda_s, scl_rise, scl_fall, start_det, stop_det;
  i2c_state_e                   state_q;
  logic [7:0]                   shift_q;
  logic [2:0]                   bit_cnt_q;
  logic [PTR_W-1:0]             ptr_q;
  logic                         rw_q, hack_q, mack_q, sda_oe_q;
  logic                         wr_strobe_q, busy_q;
  logic [7:0]                   wr_addr_q, wr_data_q;
  logic [NUM_REGS-1:0][7:0]     regs_q;
  logic [NUM_REGS-1:0][7:0]     ro_arr;
  logic [7:0]                   rx_byte_d, rd_cur_d, rd_inc_d;
  logic [PTR_W-1:0]             ptr_inc_d;

  serdesphy_i2c_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .rst        (rst),
    .scl_i      (i2c.scl_in),
    .sda_i      (i2c.sda_in),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det)
  );

  assign ro_arr = ro_data;

  always_comb begin
    rx_byte_d = {shift_q[6:0], sda_s};
    ptr_inc_d = (ptr_q == PTR_W'(NUM_REGS - 1)) ? '0 : ptr_q + PTR_W'(1);
    rd_cur_d  = RO_MASK[ptr_q]     ? ro_arr[ptr_q]     : regs_q[ptr_q];
    rd_inc_d  = RO_MASK[ptr_inc_d] ? ro_arr[ptr_inc_d] : regs_q[ptr_inc_d];
  end

  // ACK states: first SCL fall drives the ACK, second releases it and moves on.
  // RDATA_HACK: hack_q separates the fall after data bit 0 from the one after the master ACK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      hack_q      <= 1'b0;
      mack_q      <= 1'b0;
      sda_oe_q    <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      regs_q      <= RESET_VAL;
    end else begin
      wr_strobe_q <= 1'b0;
      if (start_det) begin
        state_q   <= ST_DEV_ADDR;
        bit_cnt_q <= '0;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b1;
      end else if (stop_det) begin
        state_q  <= ST_IDLE;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_DEV_ADDR: if (scl_rise) begin
            shift_q   <= rx_byte_d;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (rx_byte_d[7:1] == I2C_ADDR) begin
                rw_q    <= rx_byte_d[0];
                state_q <= ST_DEV_ACK;
              end else begin
                state_q <= ST_IGNORE;
              end
            end
          end
          ST_DEV_ACK: if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_q <= ~I2C_ACK;
            end else if (rw_q) begin
              shift_q   <= rd_cur_d;
              sda_oe_q  <= ~rd_cur_d[7];
              bit_cnt_q <= '0;
              state_q   <= ST_RDATA;
            end else begin
              sda_oe_q  <= 1'b0;
              bit_cnt_q <= '0;
              state_q   <= ST_PTR;
            end
          end
          ST_PTR: if (scl_rise) begin
            shift_q   <= rx_byte_d;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (32'(rx_byte_d) >= NUM_REGS) begin
                state_q <= ST_IGNORE;
              end else begin
                ptr_q   <= rx_byte_d[PTR_W-1:0];
                state_q <= ST_PTR_ACK;
              end
            end
          end
          ST_WDATA: if (scl_rise) begin
            shift_q   <= rx_byte_d;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (!RO_MASK[ptr_q]) begin
                regs_q[ptr_q] <= rx_byte_d;
                wr_strobe_q   <= 1'b1;
                wr_addr_q     <= 8'(ptr_q);
                wr_data_q     <= rx_byte_d;
              end
              ptr_q   <= ptr_inc_d;
              state_q <= ST_WDATA_ACK;
            end
          end
          ST_PTR_ACK, ST_WDATA_ACK: if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_q <= ~I2C_ACK;
            end else begin
              sda_oe_q  <= 1'b0;
              bit_cnt_q <= '0;
              state_q   <= ST_WDATA;
            end
          end
          ST_RDATA: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                hack_q  <= 1'b0;
                state_q <= ST_RDATA_HACK;
              end
            end else if (scl_fall) begin
              shift_q  <= {shift_q[6:0], 1'b0};
              sda_oe_q <= ~shift_q[6];
            end
          end
          ST_RDATA_HACK: begin
            if (scl_rise) begin
              hack_q <= 1'b1;
              mack_q <= (sda_s != I2C_NACK);
            end else if (scl_fall) begin
              if (!hack_q) begin
                sda_oe_q <= 1'b0;
              end else if (mack_q) begin
                ptr_q     <= ptr_inc_d;
                shift_q   <= rd_inc_d;
                sda_oe_q  <= ~rd_inc_d[7];
                bit_cnt_q <= '0;
                state_q   <= ST_RDATA;
              end else begin
                state_q <= ST_IGNORE;
              end
            end
          end
          ST_IDLE, ST_IGNORE: ;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_q[g*8 +: 8] = RO_MASK[g] ? 8'h00 : regs_q[g];
  end

  assign i2c.sda_out = 1'b0;
  assign i2c.sda_oe  = sda_oe_q;
  assign wr_strobe   = wr_strobe_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign busy        = busy_q;

endmodule
